// File: rtl/pipelined_rca_adder_if.sv
// Operand/result handshake bundle for pipelined_rca_adder.
// master drives operands and consumes results; slave is the adder.
interface pipelined_rca_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder/subtractor: one BLOCK-bit ripple
// segment and one register per stage, valid/ready on both ends.
module pipelined_rca_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input logic                 clk,
    input logic                 rst,
    pipelined_rca_adder_if.slave bus
);
    localparam int STAGES = WIDTH / BLOCK;

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic             in_fire;

    // subtract is a + ~b + ~cin
    assign b_eff   = bus.sub ? ~bus.b : bus.b;
    assign cin_eff = bus.cin ^ bus.sub;

    assign bus.in_ready = !stg[0].v_q || stg[0].adv;
    assign in_fire      = bus.in_valid && bus.in_ready;

    for (genvar g = 0; g < STAGES; g++) begin : stg
        // unconsumed operand width seen by this stage
        localparam int IW = WIDTH - g * BLOCK;
        // sum bits resolved once this stage has run
        localparam int LO = (g + 1) * BLOCK;

        logic [IW-1:0]    ain;
        logic [IW-1:0]    bin;
        logic             ci;
        logic             load;
        logic             adv;
        logic [BLOCK-1:0] blk;
        logic [BLOCK:0]   cc;
        logic [LO-1:0]    s_d;
        logic [LO-1:0]    s_q;
        logic             c_q;
        logic             v_q;

        if (g == 0) begin : src
            assign ain  = bus.a;
            assign bin  = b_eff;
            assign ci   = cin_eff;
            assign load = in_fire;
            assign s_d  = blk;
        end else begin : src
            assign ain  = stg[g-1].opnd.a_q;
            assign bin  = stg[g-1].opnd.b_q;
            assign ci   = stg[g-1].c_q;
            assign load = stg[g-1].adv;
            assign s_d  = {blk, stg[g-1].s_q};
        end

        if (g == STAGES - 1) begin : flow
            assign adv = v_q && bus.out_ready;
        end else begin : flow
            assign adv = v_q && (!stg[g+1].v_q || stg[g+1].adv);
        end

        // ripple this segment's full adders, lsb first
        always_comb begin
            blk   = '0;
            cc    = '0;
            cc[0] = ci;
            for (int i = 0; i < BLOCK; i++) begin
                blk[i]   = ain[i] ^ bin[i] ^ cc[i];
                cc[i+1]  = (ain[i] & bin[i])
                         | (cc[i] & (ain[i] ^ bin[i]));
            end
        end

        // stage occupancy: fill from upstream, drain when advancing
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
            end else if (load) begin
                v_q <= 1'b1;
            end else if (adv) begin
                v_q <= 1'b0;
            end
        end

        // partial sum and carry, held while stalled
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s_q <= '0;
                c_q <= 1'b0;
            end else if (load) begin
                s_q <= s_d;
                c_q <= cc[BLOCK];
            end
        end

        if (IW > BLOCK) begin : opnd
            logic [IW-BLOCK-1:0] a_q;
            logic [IW-BLOCK-1:0] b_q;

            // carry forward the operand bits later stages still need
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (load) begin
                    a_q <= ain[IW-1:BLOCK];
                    b_q <= bin[IW-1:BLOCK];
                end
            end
        end

        if (g == STAGES - 1) begin : msb
            logic cm_q;

            // carry into the result msb, needed for signed overflow
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cm_q <= 1'b0;
                end else if (load) begin
                    cm_q <= cc[BLOCK-1];
                end
            end
        end
    end

    assign bus.out_valid = stg[STAGES-1].v_q;
    assign bus.sum       = stg[STAGES-1].s_q;
    assign bus.cout      = stg[STAGES-1].c_q;
    assign bus.ovf       = stg[STAGES-1].msb.cm_q ^ stg[STAGES-1].c_q;
endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Self-checking bench for pipelined_rca_adder (WIDTH=16, BLOCK=4).
// Scoreboard queue of expected results, table plus directed and random.
module tb_pipelined_rca_adder;
    localparam int W  = 16;
    localparam int BL = 4;
    localparam int ST = W / BL;

    typedef logic [W+1:0] res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   rnd_on = 1'b0;
    bit   stalled = 1'b0;
    res_t held;
    res_t sb[$];
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    pipelined_rca_adder_if #(.WIDTH(W)) bus ();

    pipelined_rca_adder #(
        .WIDTH(W),
        .BLOCK(BL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input logic ci, input logic su);
        int sa = $signed(a);
        int sbv = $signed(b);
        int r;
        logic [W:0] full;
        logic ov;
        if (!su) begin
            full = {1'b0, a} + {1'b0, b} + 17'(ci);
            r    = sa + sbv + int'(ci);
        end else begin
            full = {1'b0, a} - {1'b0, b} - 17'(ci);
            full[W] = ~full[W];
            r    = sa - sbv - int'(ci);
        end
        ov = (r > 32767) || (r < -32768);
        return {full[W-1:0], full[W], ov};
    endfunction

    // result scoreboard and hold-while-stalled check
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled)
                check("stall_hold",
                      {bus.out_valid, bus.sum, bus.cout, bus.ovf},
                      {1'b1, held});
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL extra_beat: got %0h want none",
                             bus.sum);
                end else begin
                    check("result", {bus.sum, bus.cout, bus.ovf},
                          sb.pop_front());
                end
            end
            stalled = bus.out_valid && !bus.out_ready;
            held    = {bus.sum, bus.cout, bus.ovf};
        end
    end

    // random consumer backpressure
    always @(posedge clk) begin
        if (rnd_on) begin
            #1;
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // entry: just after a posedge; exit: just after a later posedge
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic su, input res_t exp);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.cin = ci;
        bus.sub = su;
        @(negedge clk);
        while (!bus.in_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (!bus.in_ready)
            check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        else
            sb.push_back(exp);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic lat_beat(input logic [W-1:0] a, input logic [W-1:0] b);
        int cnt;
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.cin = 1'b0;
        bus.sub = 1'b0;
        @(negedge clk);
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
        sb.push_back(model(a, b, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        cnt = 1;
        @(negedge clk);
        while (!bus.out_valid && cnt < 20) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        check("latency", 32'(cnt), 32'(ST));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        check("drain", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[12];
        bit   saw_low;

        tbl[0]  = '{16'h1234, 16'h4321, 0, 0, 16'h5555, 0, 0};
        tbl[1]  = '{16'hFFFF, 16'h0000, 1, 0, 16'h0000, 1, 0};
        tbl[2]  = '{16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1};
        tbl[3]  = '{16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0};
        tbl[4]  = '{16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1};
        tbl[5]  = '{16'h0000, 16'h0000, 0, 1, 16'h0000, 1, 0};
        tbl[6]  = '{16'h0000, 16'h0000, 1, 1, 16'hFFFF, 0, 0};
        tbl[7]  = '{16'h8000, 16'h8000, 0, 0, 16'h0000, 1, 1};
        tbl[8]  = '{16'hFFFF, 16'hFFFF, 1, 0, 16'hFFFF, 1, 0};
        tbl[9]  = '{16'h00F0, 16'h0010, 0, 0, 16'h0100, 0, 0};
        tbl[10] = '{16'h0FFF, 16'h0001, 0, 0, 16'h1000, 0, 0};
        tbl[11] = '{16'h7FFF, 16'hFFFF, 0, 1, 16'h8000, 0, 1};

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;

        lat_beat(16'h1234, 16'h4321);
        drain();

        for (int i = 0; i < 12; i++)
            send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub,
                 {tbl[i].s, tbl[i].co, tbl[i].ov});
        drain();

        saw_low = 1'b0;
        fork
            begin
                for (int i = 1; i <= 8; i++)
                    send(16'(i), 16'(i), 1'b0, 1'b0, {16'(2 * i), 2'b00});
            end
            begin
                repeat (4) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
            begin
                repeat (20) begin
                    @(negedge clk);
                    if (!bus.in_ready && bus.out_valid && !bus.out_ready)
                        saw_low = 1'b1;
                end
            end
        join
        check("bp_in_ready_low", 32'(saw_low), 32'd1);
        drain();

        bus.out_ready = 1'b0;
        for (int i = 1; i <= 4; i++)
            send(16'h0101 * 16'(i), 16'h0202, 1'b0, 1'b0,
                 model(16'h0101 * 16'(i), 16'h0202, 1'b0, 1'b0));
        @(negedge clk);
        check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        check("pre_rst_sum", 32'(bus.sum), 32'h0303);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_sum", 32'(bus.sum), 32'd0);
        check("mid_rst_cout", 32'(bus.cout), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        lat_beat(16'hABCD, 16'h1111);
        drain();

        rnd_on = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic rc;
            logic rs;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
            send(ra, rb, rc, rs, model(ra, rb, rc, rs));
        end
        rnd_on = 1'b0;
        @(posedge clk);
        #2 bus.out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
